// File: rtl/nibble_serial_adder.sv
// -----------------------------------------------------------------------------
// nibble_serial_adder
//
// Multi-cycle WIDTH-bit adder/subtractor built around one 4-bit carry-lookahead
// slice. It processes one nibble per cycle, LSB first. A registered carry links
// consecutive nibbles. Subtraction is A + ~B + 1.
//
// Ports
//   clk       : clock; all state updates on the rising edge
//   rst_n     : asynchronous active-low reset
//   in_valid  : request valid
//   in_ready  : block can accept a request (state == IDLE)
//   a, b      : operands, sampled on accept
//   sub       : 0 = A+B+cin, 1 = A-B (cin ignored), sampled on accept
//   cin       : carry-in for add, sampled on accept
//   out_valid : result valid (state == DONE)
//   out_ready : consumer accepts the result
//   sum       : result, modulo 2^WIDTH
//   cout      : carry out of the MSB; for sub, 1 = no borrow
//   overflow  : signed two's-complement overflow
// -----------------------------------------------------------------------------
module nibble_serial_adder #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow
);

   localparam int NIB = WIDTH / 4;
   localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
   localparam logic [CW-1:0] LAST = CW'(NIB - 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t           state, state_next;
   logic [WIDTH-1:0] a_reg, b_reg, sum_reg;
   logic [CW-1:0]    cnt;
   logic             carry, cout_reg, ovf_reg;
   logic             accept, last;

   logic [3:0]       a_nib, b_nib, g, p, s_nib;
   logic             c1, c2, c3, c4;

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign accept    = in_valid && in_ready;
   assign last      = (cnt == LAST);

   assign sum      = sum_reg;
   assign cout     = cout_reg;
   assign overflow = ovf_reg;

   // Select the current nibble of each operand. A compare-per-nibble mux keeps
   // every part-select index constant.
   // NOTE: every always_comb output gets a default first, so no path through the block can infer a latch.
   always_comb begin
      a_nib = '0;
      b_nib = '0;
      for (int k = 0; k < NIB; k++) begin
         if (cnt == CW'(k)) begin
            a_nib = a_reg[4*k +: 4];
            b_nib = b_reg[4*k +: 4];
         end
      end
   end

   // 4-bit carry-lookahead slice. The only carry input is the carry register,
   // so there is no combinational path from a/b to sum.
   assign g  = a_nib & b_nib;
   assign p  = a_nib ^ b_nib;
   assign c1 = g[0] | (p[0] & carry);
   assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry);
   assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & carry);
   assign c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]) | ((&p) & carry);
   assign s_nib = p ^ {c3, c2, c1, carry};

   // NOTE: sequential state is assigned only with non-blocking (<=) so all registers update together at the edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:    if (accept)    state_next = BUSY;
         BUSY:    if (last)      state_next = DONE;
         DONE:    if (out_ready) state_next = IDLE;
         default:                state_next = IDLE;
      endcase
   end

   // NOTE: every register, including the operand latches, is reset. This lets an abort in BUSY or DONE return all outputs to known values at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_reg    <= '0;
         b_reg    <= '0;
         sum_reg  <= '0;
         cnt      <= '0;
         carry    <= 1'b0;
         cout_reg <= 1'b0;
         ovf_reg  <= 1'b0;
      end else if (accept) begin
         // Subtraction is A + ~B + 1, so the operand is inverted here and the
         // carry-in is forced to 1.
         a_reg   <= a;
         b_reg   <= b ^ {WIDTH{sub}};
         carry   <= sub ? 1'b1 : cin;
         sum_reg <= '0;
         cnt     <= '0;
      end else if (state == BUSY) begin
         for (int k = 0; k < NIB; k++) begin
            if (cnt == CW'(k)) sum_reg[4*k +: 4] <= s_nib;
         end
         carry <= c4;
         if (last) begin
            cout_reg <= c4;
            // c3 is the carry into the MSB and c4 is the carry out of it.
            ovf_reg  <= c3 ^ c4;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_nibble_serial_adder
//
// Self-checking bench for nibble_serial_adder (WIDTH = 32). It covers:
//   - reset state
//   - directed add and sub vectors
//   - output backpressure
//   - asynchronous reset in the middle of an operation
//   - random operations with input and output stalls
// -----------------------------------------------------------------------------
module tb_nibble_serial_adder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready;
   logic [31:0] a, b;
   logic        sub, cin;
   logic        out_valid, out_ready;
   logic [31:0] sum;
   logic        cout, overflow;

   int vectors     = 0;
   int miscompares = 0;

   nibble_serial_adder #(.WIDTH(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .sub       (sub),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   // Drives one operation and returns what the DUT produced:
   //   pre     : idle cycles before the request is raised
   //   hold    : cycles in DONE with out_ready low, while in_valid and a/b toggle
   //   lat     : rising edges from the accept edge to out_valid (40 = timeout)
   //   stable  : outputs held and in_ready stayed low during the hold
   //   idle_ok : IDLE was reached one edge after out_ready
   task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_v,
                         input logic tsub, input logic tcin,
                         input int pre, input int hold,
                         output logic [31:0] rs, output logic rc,
                         output logic ro, output int lat,
                         output logic stable, output logic idle_ok);
      repeat (pre) @(negedge clk);
      @(negedge clk);
      a = ta; b = tb_v; sub = tsub; cin = tcin; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      a = $urandom; b = $urandom; sub = ~tsub; cin = ~tcin;
      lat = 0;
      while (out_valid !== 1'b1 && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
      rs = sum; rc = cout; ro = overflow;
      stable = 1'b1;
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         in_valid = h[0] ? 1'b0 : 1'b1;
         a = $urandom; b = $urandom; sub = $urandom; cin = $urandom;
         @(posedge clk);
         #1;
         if (sum !== rs || cout !== rc || overflow !== ro ||
             out_valid !== 1'b1 || in_ready !== 1'b0) stable = 1'b0;
      end
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      idle_ok   = (in_ready === 1'b1) && (out_valid === 1'b0);
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      a = '0; b = '0; sub = 1'b0; cin = 1'b0;
      #1;
      vectors++;
      if ({out_valid, in_ready, cout, overflow} !== 4'b0100 || sum !== 32'h0) begin
         miscompares++;
         $display("FAIL reset: out_valid=%b in_ready=%b cout=%b ovf=%b sum=%h, want 0 1 0 0 00000000",
                  out_valid, in_ready, cout, overflow, sum);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_directed();
      logic [31:0] va [5] = '{32'hFFFFFFFF, 32'h7FFFFFFF, 32'h12345678, 32'h00000005, 32'h80000000};
      logic [31:0] vb [5] = '{32'h00000001, 32'h00000001, 32'h9ABCDEF0, 32'h00000007, 32'h00000001};
      logic        vs [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      logic        vc [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      logic [31:0] es [5] = '{32'h00000000, 32'h80000000, 32'hACF13569, 32'hFFFFFFFE, 32'h7FFFFFFF};
      logic        ec [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      logic        eo [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      logic [31:0] rs;
      logic        rc, ro, st, io;
      int          lat;
      for (int i = 0; i < 5; i++) begin
         run_op(va[i], vb[i], vs[i], vc[i], 0, 0, rs, rc, ro, lat, st, io);
         vectors++;
         if (rs !== es[i]) begin
            miscompares++;
            $display("FAIL directed[%0d] sum: got %h want %h", i, rs, es[i]);
         end
         vectors++;
         if (rc !== ec[i] || ro !== eo[i]) begin
            miscompares++;
            $display("FAIL directed[%0d] cout/ovf: got %b/%b want %b/%b", i, rc, ro, ec[i], eo[i]);
         end
         vectors++;
         if (lat != 8) begin
            miscompares++;
            $display("FAIL directed[%0d] latency: got %0d want 8", i, lat);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] rs;
      logic        rc, ro, st, io;
      int          lat;
      run_op(32'h0F0F0F0F, 32'h01010101, 1'b0, 1'b0, 1, 5, rs, rc, ro, lat, st, io);
      vectors++;
      if (rs !== 32'h10101010 || rc !== 1'b0 || ro !== 1'b0) begin
         miscompares++;
         $display("FAIL backpressure result: got %h/%b/%b want 10101010/0/0", rs, rc, ro);
      end
      vectors++;
      if (st !== 1'b1) begin
         miscompares++;
         $display("FAIL backpressure hold: outputs or in_ready changed while stalled (got %b want 1)", st);
      end
      vectors++;
      if (io !== 1'b1) begin
         miscompares++;
         $display("FAIL backpressure release: got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
      end
   endtask

   task automatic test_reset_mid_busy();
      logic [31:0] rs;
      logic        rc, ro, st, io;
      int          lat;
      @(negedge clk);
      a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; sub = 1'b0; cin = 1'b1; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      vectors++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || sum !== 32'h0 || cout !== 1'b0 || overflow !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_mid_busy: out_valid=%b in_ready=%b sum=%h cout=%b ovf=%b want 0 1 00000000 0 0",
                  out_valid, in_ready, sum, cout, overflow);
      end
      @(negedge clk);
      rst_n = 1'b1;
      run_op(32'h00000010, 32'h000000F0, 1'b0, 1'b0, 0, 0, rs, rc, ro, lat, st, io);
      vectors++;
      if (rs !== 32'h00000100 || rc !== 1'b0 || ro !== 1'b0) begin
         miscompares++;
         $display("FAIL after_reset add: got %h/%b/%b want 00000100/0/0", rs, rc, ro);
      end
   endtask

   task automatic test_random();
      logic [31:0] ra, rb, rs, es;
      logic        rsub, rcin, rc, ro, st, io, ec, eo;
      logic [32:0] full;
      int          lat;
      for (int i = 0; i < 1000; i++) begin
         ra = $urandom; rb = $urandom; rsub = $urandom; rcin = $urandom;
         if (i % 10 == 0) begin ra = rb; end
         if (rsub) begin
            es = ra - rb;
            ec = (ra >= rb);
            eo = (ra[31] != rb[31]) && (es[31] != ra[31]);
         end else begin
            full = {1'b0, ra} + {1'b0, rb} + {32'b0, rcin};
            es = full[31:0];
            ec = full[32];
            eo = (ra[31] == rb[31]) && (es[31] != ra[31]);
         end
         run_op(ra, rb, rsub, rcin, $urandom_range(0, 2), $urandom_range(0, 3),
                rs, rc, ro, lat, st, io);
         vectors++;
         if (rs !== es || rc !== ec || ro !== eo || lat != 8 || st !== 1'b1 || io !== 1'b1) begin
            miscompares++;
            $display("FAIL random[%0d] a=%h b=%h sub=%b cin=%b: got %h/%b/%b lat=%0d st=%b io=%b want %h/%b/%b lat=8 st=1 io=1",
                     i, ra, rb, rsub, rcin, rs, rc, ro, lat, st, io, es, ec, eo);
         end
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_backpressure();
      test_reset_mid_busy();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
- Multi-cycle WIDTH-bit adder/subtractor built around a single 4-bit carry-lookahead slice.
- Processes one nibble per cycle, LSB first, with a registered inter-nibble carry.
- Sits directly upstream of, and wraps, the 4-bit CLA adder stage: it feeds nibble operands and carry-in and consumes nibble sum/carry-out.
- Small-area arithmetic for the npc datapath, with valid/ready handshakes on both sides.

Parameters:
- WIDTH, 32: operand/result width; must be a multiple of 4 and ≥ 8. NIB = WIDTH/4 cycles per operation.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request; equals (state == IDLE).
- a  input  WIDTH  operand A, sampled on accept.
- b  input  WIDTH  operand B, sampled on accept.
- sub  input  1  0: A+B+cin; 1: A−B (cin ignored), sampled on accept.
- cin  input  1  carry-in for add, sampled on accept.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  result.
- cout  output  1  carry out of MSB; for sub, 1 = no borrow.
- overflow  output  1  signed overflow.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, nibble counter=0, carry reg=0.
  - sum=0, cout=0, overflow=0, out_valid=0; in_ready=1 once state is IDLE.
- FSM has three states: IDLE, BUSY, DONE.
  - IDLE: on in_valid && in_ready:
    - latch a, b^{WIDTH{sub}}, and carry = sub ? 1 : cin;
    - clear sum, counter=0; go to BUSY.
  - BUSY: each cycle processes nibble k=counter.
    - Slice: g=a_k & b'_k, p=a_k ^ b'_k.
    - Lookahead carries c1..c4 computed from g, p and carry reg.
    - sum[4k+3:4k] <= p ^ {c3,c2,c1,c0}; carry reg <= c4; counter++.
    - When k == NIB−1: cout <= c4, overflow <= c3 ^ c4, go to DONE.
  - DONE: out_valid=1. sum/cout/overflow held stable until out_ready=1; then go to IDLE.
- Timing:
  - Latency: out_valid rises after exactly NIB rising edges following the accept edge (8 for WIDTH=32).
  - Max throughput: one op per NIB+2 cycles.
- Handshake rules:
  - in_ready=0 in BUSY and DONE; in_valid is ignored there and a/b/sub/cin may change freely.
  - No same-cycle accept on the DONE→IDLE transition.
  - out_valid, once high, must not drop without out_ready=1 (or reset).
- Carry chain:
  - The carry register is the only inter-nibble path; no combinational path from a/b to sum.
  - Counter wraps only through IDLE (reset to 0 on accept).
- Output registers:
  - sum bits of unprocessed nibbles read 0 during BUSY.
  - Outputs are meaningful only while out_valid=1.
- Reset mid-operation (BUSY or DONE): in-flight result discarded, all outputs return to reset values immediately; next accepted op is computed correctly.
- Arithmetic: modulo 2^WIDTH.
  - Add: {cout,sum} = a+b+cin.
  - Sub: sum = a−b; cout = (a ≥ b unsigned).
  - overflow = signed two's-complement overflow in both modes.

Test Plan:
- add a=0xFFFFFFFF, b=0x00000001, cin=0 -> sum=0x00000000, cout=1, overflow=0; out_valid high exactly 8 edges after accept.
- add a=0x7FFFFFFF, b=0x00000001, cin=0 -> sum=0x80000000, cout=0, overflow=1.
- add a=0x12345678, b=0x9ABCDEF0, cin=1 -> sum=0xACF13569, cout=0, overflow=0.
- sub 5−7 -> sum=0xFFFFFFFE, cout=0, overflow=0.
- sub 0x80000000−1 -> sum=0x7FFFFFFF, cout=1, overflow=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while toggling in_valid and a/b:
  - sum/cout/overflow stay stable, in_ready=0, no new op accepted;
  - out_ready=1 -> IDLE next edge, in_ready=1.
- Async reset asserted mid-BUSY at nibble 3:
  - out_valid=0, sum=0, in_ready=1 immediately;
  - subsequent add 0x00000010+0x000000F0 -> sum=0x00000100, cout=0.
- 1000 random ops with random in_valid/out_ready stalls, both modes, checked against a behavioural model; includes sub with cin=1 to confirm cin is ignored.
